// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, PC step
// and the width of one queued {pc, inst} entry.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   localparam logic [31:0] PC_STEP = 32'd4;
   localparam int          ENTRY_W = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries; flush empties it in one
// cycle and wins over a same-cycle push or pop.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: nothing is read until count says it was written.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one outstanding word request at a time
// over req/ack, and queues returned words with their PC for the processor.
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   RESET_N,
   input  logic                   redirect_i,
   input  logic [31:0]            redirect_pc_i,
   output logic                   mem_req_o,
   output logic [31:0]            mem_addr_o,
   input  logic                   mem_ack_i,
   input  logic [31:0]            mem_data_i,
   output logic                   inst_valid_o,
   output logic [31:0]            inst_o,
   output logic [31:0]            inst_pc_o,
   input  logic                   inst_ready_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic [1:0]             fsm_state
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Handshakes: a memory transfer completes in any cycle with mem_req_o & mem_ack_i,
   // and mem_addr_o is held until then; an instruction is consumed in any cycle
   // with inst_valid_o & inst_ready_i.

   state_t              state, state_n;
   logic [31:0]         fetch_pc, pc_n;
   logic [31:0]         hold_addr, hold_n;
   logic [31:0]         redir_pc;
   logic                push, pop;
   logic                full, empty;
   logic [CW-1:0]       count;
   logic [CW:0]         count_after;
   logic [ENTRY_W-1:0]  head;
   logic                unused_bits;

   assign redir_pc    = {redirect_pc_i[31:2], 2'b00};
   assign unused_bits = ^redirect_pc_i[1:0];
   assign pop         = !empty && inst_ready_i;
   assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         hold_addr <= RESET_PC;
      end else begin
         state     <= state_n;
         fetch_pc  <= pc_n;
         hold_addr <= hold_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = fetch_pc;
      hold_n  = hold_addr;
      push    = 1'b0;
      case (state)
         IDLE: begin
            if (redirect_i) pc_n = redir_pc;
            if (!full || pop || redirect_i) state_n = REQ;
         end
         REQ: begin
            if (redirect_i) begin
               pc_n = redir_pc;
               // Redirect before the ack: the old request is still owed a reply.
               if (!mem_ack_i) begin
                  hold_n  = fetch_pc;
                  state_n = DISCARD;
               end
            end else if (mem_ack_i) begin
               push = 1'b1;
               pc_n = fetch_pc + PC_STEP;
               if (count_after >= (CW+1)'(DEPTH)) state_n = IDLE;
            end
         end
         DISCARD: begin
            if (redirect_i) pc_n = redir_pc;
            if (mem_ack_i)  state_n = REQ;
         end
         default: state_n = IDLE;
      endcase
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (RESET_N),
      .push  (push),
      .pop   (pop),
      .flush (redirect_i),
      .wdata ({fetch_pc, mem_data_i}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign mem_req_o    = (state == REQ) || (state == DISCARD);
   assign mem_addr_o   = (state == DISCARD) ? hold_addr : fetch_pc;
   assign inst_valid_o = !empty;
   assign inst_o       = empty ? 32'd0 : head[31:0];
   assign inst_pc_o    = empty ? 32'd0 : head[63:32];
   assign count_o      = count;
   assign fsm_state    = state;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed phases plus random traffic, checked each
// cycle against a transaction-level model of the fetch queue.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        RESET_N;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i;
   logic [2:0]  count_o;
   logic [1:0]  fsm_state;

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .RESET_N       (RESET_N),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_data_i    (mem_data_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_ready_i  (inst_ready_i),
      .count_o       (count_o),
      .fsm_state     (fsm_state)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: queue of {pc, inst}, next PC to fetch, and the single
   // outstanding request (its address and whether its data will be dropped).
   logic [63:0] exp_q[$];
   logic [31:0] m_fetch;
   logic [31:0] m_addr;
   bit          m_pending;
   bit          m_discard;
   int          max_wait;
   int          wait_left;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_values();
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_addr", mem_addr_o, RESET_PC);
      chk("rst_inst_valid", inst_valid_o, 0);
      chk("rst_inst", inst_o, 0);
      chk("rst_inst_pc", inst_pc_o, 0);
      chk("rst_count", count_o, 0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_fetch   = RESET_PC;
      m_addr    = RESET_PC;
      m_pending = 0;
      m_discard = 0;
      wait_left = $urandom_range(0, max_wait);
   endtask

   task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
      bit          ack, pop, was_pending;
      int          sz_before;
      logic [31:0] rpc_al;
      @(negedge clk);
      ack = 0;
      if (m_pending) begin
         if (wait_left == 0) begin
            ack       = 1;
            wait_left = $urandom_range(0, max_wait);
         end else begin
            wait_left--;
         end
      end
      redirect_i    = redir;
      redirect_pc_i = rpc;
      inst_ready_i  = rdy;
      mem_ack_i     = ack;
      mem_data_i    = ack ? mem_word(m_addr) : $urandom;
      #1;
      chk("mem_req", mem_req_o, m_pending);
      if (m_pending) chk("mem_addr", mem_addr_o, m_addr);
      chk("count", count_o, exp_q.size());
      chk("count_bound", count_o <= DEPTH, 1);
      chk("inst_valid", inst_valid_o, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         chk("inst_pc", inst_pc_o, exp_q[0][63:32]);
         chk("inst", inst_o, exp_q[0][31:0]);
      end

      pop         = (exp_q.size() > 0) && rdy;
      sz_before   = exp_q.size();
      was_pending = m_pending;
      rpc_al      = {rpc[31:2], 2'b00};
      if (pop) void'(exp_q.pop_front());
      if (m_pending && ack && !m_discard && !redir) begin
         exp_q.push_back({m_addr, mem_word(m_addr)});
         m_fetch = m_addr + 32'd4;
      end
      if (redir) begin
         exp_q.delete();
         m_fetch = rpc_al;
      end
      if (!was_pending) begin
         if (redir || pop || sz_before < DEPTH) begin
            m_pending = 1;
            m_discard = 0;
            m_addr    = m_fetch;
         end
      end else if (ack) begin
         if (m_discard || redir) begin
            m_discard = 0;
            m_addr    = m_fetch;
         end else begin
            m_pending = (exp_q.size() < DEPTH);
            m_addr    = m_fetch;
         end
      end else if (redir) begin
         m_discard = 1;
      end
   endtask

   task automatic run(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(0, 32'd0, rdy);
   endtask

   task automatic async_reset_pulse();
      @(negedge clk);
      mem_ack_i  = 0;
      redirect_i = 0;
      #2 RESET_N = 0;
      #1 chk_reset_values();
      @(posedge clk);
      #2 RESET_N = 1;
      model_reset();
   endtask

   initial begin
      RESET_N       = 1;
      redirect_i    = 0;
      redirect_pc_i = 0;
      mem_ack_i     = 0;
      mem_data_i    = 0;
      inst_ready_i  = 0;
      max_wait      = 0;
      #1 RESET_N = 0;
      #2 chk_reset_values();
      @(posedge clk);
      @(posedge clk);
      #2 RESET_N = 1;
      model_reset();

      // Zero-wait memory, always ready: one instruction per cycle.
      max_wait = 0; wait_left = 0;
      run(16, 1);

      // Backpressure fills the queue, then drains in order.
      run(10, 0);
      run(10, 1);

      // Slow memory with a redirect while the request is waiting.
      max_wait = 3; wait_left = 3;
      cycle(1, 32'h0000_0100, 1);
      run(12, 1);

      // Redirect coinciding with an ack while two entries are queued.
      max_wait = 0; wait_left = 0;
      run(2, 0);
      cycle(1, 32'h0000_0040, 0);
      run(8, 1);

      // Full queue with simultaneous push/pop, then a misaligned redirect.
      run(6, 0);
      run(3, 1);
      run(3, 0);
      cycle(1, 32'h0000_0023, 1);
      run(6, 1);

      // PC wraps past the top of the address space.
      cycle(1, 32'hFFFF_FFF4, 1);
      run(6, 1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bit          r;
         logic [31:0] p;
         if (i % 100 == 0) max_wait = $urandom_range(0, 3);
         r = ($urandom_range(0, 11) == 0);
         p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : (32'($urandom) & 32'h0000_0FFF);
         cycle(r, p, $urandom_range(0, 3) != 0);
      end

      // Reset pulsed asynchronously while a request is outstanding.
      max_wait = 3; wait_left = 3;
      run(3, 1);
      async_reset_pulse();
      max_wait = 0; wait_left = 0;
      run(10, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
